// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side byte FIFO between the UART receiver and the
// CPU register interface. Registered pop handshake, sticky overflow flag,
// and an interrupt from a fill threshold or an idle timeout on unread data.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2048,
  localparam int unsigned LW            = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          rx_done,
  input  logic [7:0]    rx_byte,
  input  logic          rd_req,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [LW-1:0] level,
  input  logic [LW-1:0] threshold,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          timeout,
  output logic          irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILLING,
    S_STALE
  } state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    rd_data_q;
  logic          rd_valid_q;
  logic          overflow_q;
  logic          timeout_q;
  logic [CW-1:0] cnt_q;
  state_e        state_q;

  logic push, pop_acc, push_acc, drop, full, activity;

  // Handshake decode: a full FIFO still accepts a push when a pop frees a slot
  // in the same cycle; an empty FIFO never lets a push fall through to a pop.
  always_comb begin
    full     = (level_q == FULL_LVL);
    push     = en && rx_done;
    pop_acc  = rd_req && (level_q != '0);
    push_acc = push && (!full || pop_acc);
    drop     = push && full && !pop_acc;
    activity = push_acc || pop_acc;
    wptr_d   = push_acc ? wptr_q + AW'(1) : wptr_q;
    rptr_d   = pop_acc  ? rptr_q + AW'(1) : rptr_q;
    level_d  = level_q + LW'(push_acc) - LW'(pop_acc);
  end

  // Byte storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wptr_q] <= rx_byte;
  end

  // Pointers, occupancy and the registered pop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      rd_valid_q <= pop_acc;
      if (pop_acc) rd_data_q <= mem_q[rptr_q];
    end
  end

  // Sticky overflow; a drop in the same cycle wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  // Idle-timeout FSM with registered timeout output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q     <= '0;
          timeout_q <= 1'b0;
          if (push_acc) state_q <= S_FILLING;
        end
        S_FILLING: begin
          if (level_d == '0) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (activity) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q   <= S_STALE;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STALE: begin
          if (level_d == '0) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
          end else if (activity) begin
            state_q   <= S_FILLING;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  // Interrupt from registered state only; no combinational path from strobes.
  always_comb begin
    irq = ((threshold != '0) && (level_q >= threshold)) || timeout_q;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          rx_done;
  logic [7:0]    rx_byte;
  logic          rd_req;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [LW-1:0] level;
  logic [LW-1:0] threshold;
  logic          overflow;
  logic          ovf_clr;
  logic          timeout;
  logic          irq;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic [7:0] m_q[$];
  logic       m_ovf;
  logic [7:0] m_data;
  logic       m_valid;
  int         m_idle;

  uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rx_done(rx_done), .rx_byte(rx_byte),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
    .threshold(threshold), .overflow(overflow), .ovf_clr(ovf_clr),
    .timeout(timeout), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_idle  = 0;
  endtask

  // Applies one clock edge worth of the spec's rules to the model.
  task automatic model_edge();
    int  sz;
    bit  push, pop, acc;
    sz   = m_q.size();
    push = en && rx_done;
    pop  = rd_req && (sz > 0);
    acc  = push && ((sz < DEPTH) || pop);
    if (pop) m_data = m_q.pop_front();
    m_valid = pop;
    if (acc) m_q.push_back(rx_byte);
    if (push && !acc) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (acc || pop) m_idle = 0;
    else if (m_idle < 100000) m_idle++;
  endtask

  task automatic check_all();
    logic tmo;
    tmo = (m_q.size() > 0) && (m_idle >= TMO);
    chk("rd_valid", rd_valid, m_valid);
    chk("rd_data", rd_data, m_data);
    chk("level", level, m_q.size());
    chk("overflow", overflow, m_ovf);
    chk("timeout", timeout, tmo);
    chk("irq", irq, ((threshold != 0) && (m_q.size() >= threshold)) || tmo);
  endtask

  task automatic step(input logic e, input logic d, input logic [7:0] b,
                      input logic r, input logic c);
    en = e; rx_done = d; rx_byte = b; rd_req = r; ovf_clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Reset pulse placed between clock edges; outputs must clear at once.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_level_now", level, 0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rx_done = 1'b0; rx_byte = 8'h00;
    rd_req = 1'b0; ovf_clr = 1'b0; threshold = '0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Order: three bytes in, three out
    step(1, 1, 8'hA5, 0, 0);
    step(1, 1, 8'h3C, 0, 0);
    step(1, 1, 8'hFF, 0, 0);
    chk("order_level3", level, 3);
    step(1, 0, 8'h00, 1, 0); chk("order_b0", rd_data, 8'hA5);
    step(1, 0, 8'h00, 1, 0); chk("order_b1", rd_data, 8'h3C);
    step(1, 0, 8'h00, 1, 0); chk("order_b2", rd_data, 8'hFF);
    step(1, 0, 8'h00, 1, 0); chk("empty_pop_novalid", rd_valid, 0);

    // Full and overflow
    for (int i = 0; i < 16; i++) step(1, 1, 8'(i), 0, 0);
    step(1, 1, 8'h55, 0, 0);
    chk("ovf_level", level, 16);
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'h00, 1, 0);
      chk("drain_byte", rd_data, 8'(i));
    end
    chk("drain_level", level, 0);
    step(1, 0, 8'h00, 0, 1);
    chk("ovf_clr", overflow, 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) step(1, 1, 8'(8'h40 + i), 0, 0);
    step(1, 1, 8'h77, 1, 0);
    chk("full_pp_level", level, 16);
    chk("full_pp_ovf", overflow, 0);
    chk("full_pp_data", rd_data, 8'h40);
    for (int i = 0; i < 16; i++) step(1, 0, 8'h00, 1, 0);
    chk("full_pp_last", rd_data, 8'h77);

    // Empty with simultaneous push and pop
    step(1, 1, 8'h99, 1, 0);
    chk("empty_pp_valid", rd_valid, 0);
    chk("empty_pp_level", level, 1);
    step(1, 0, 8'h00, 1, 0);
    chk("empty_pp_data", rd_data, 8'h99);

    // Threshold
    threshold = 5'd4;
    for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h10 + i), 0, 0);
    chk("thr_below", irq, 0);
    step(1, 1, 8'h13, 0, 0);
    chk("thr_hit", irq, 1);
    step(1, 0, 8'h00, 1, 0);
    chk("thr_after_pop", irq, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1, 0);
    threshold = '0;

    // Timeout
    step(1, 1, 8'hC3, 0, 0);
    idle(TMO - 1);
    chk("tmo_not_yet", timeout, 0);
    idle(1);
    chk("tmo_rise", timeout, 1);
    chk("tmo_irq", irq, 1);
    idle(3);
    step(1, 0, 8'h00, 1, 0);
    chk("tmo_fall", timeout, 0);
    chk("tmo_irq_fall", irq, 0);
    chk("tmo_level", level, 0);

    // Enable low ignores strobes
    for (int i = 0; i < 5; i++) step(0, 1, 8'hEE, 0, 0);
    chk("en_level", level, 0);
    chk("en_ovf", overflow, 0);

    // Asynchronous reset with data buffered
    for (int i = 0; i < 6; i++) step(1, 1, 8'(8'h60 + i), 0, 0);
    chk("pre_rst_level", level, 6);
    mid_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1, 0);
    chk("post_rst_valid", rd_valid, 0);

    // Random traffic with shifting push/pop bias
    for (int i = 0; i < 4000; i++) begin
      int unsigned ppush, ppop;
      if (i % 250 == 0) threshold = LW'($urandom_range(0, DEPTH));
      case ((i / 400) % 4)
        0: begin ppush = 80; ppop = 20; end
        1: begin ppush = 20; ppop = 80; end
        2: begin ppush = 5;  ppop = 5;  end
        default: begin ppush = 60; ppop = 60; end
      endcase
      step(($urandom_range(0, 99) < 90),
           ($urandom_range(0, 99) < ppush),
           8'($urandom),
           ($urandom_range(0, 99) < ppop),
           ($urandom_range(0, 99) < 5));
      if ($urandom_range(0, 999) == 0) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
